// File: rtl/aes_ahb_slave_if.sv
// AHB-Lite slave front end for the AES accelerator: control/key/data-block registers,
// an in-order input slot ring feeding the core, and an output slot ring for bus read-back.
`timescale 1ns/1ps
module aes_ahb_slave_if #(
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         HSELx,
  input  logic [31:0]  HADDR,
  input  logic [31:0]  HWDATA,
  input  logic [1:0]   HTRANS,
  input  logic         HWRITE,
  input  logic [2:0]   HSIZE,
  input  logic [2:0]   HBURST,
  input  logic [3:0]   HPROT,
  output logic [31:0]  HRDATA,
  output logic         HREADY,
  output logic [1:0]   HRESP,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic         mode,
  output logic [127:0] in_block,
  output logic         in_valid,
  input  logic         in_ready,
  input  logic [127:0] out_block,
  input  logic         out_valid,
  output logic         out_ready
);

  typedef enum logic [1:0] {PH_IDLE, PH_DATA, PH_ERR1, PH_ERR2} phase_t;

  phase_t               r_ph;
  logic                 r_dp_write;
  logic [5:0]           r_dp_word;
  logic [127:0]         r_key;
  logic                 r_key_loaded;
  logic                 r_key_valid;
  logic                 r_mode;
  logic [127:0]         r_in_mem  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_in_full;
  logic [1:0]           r_in_rd;
  logic [127:0]         r_out_mem [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_out_full;
  logic [1:0]           r_out_wr;

  logic        w_unused;
  logic [5:0]  w_aw;
  logic        w_ok;
  logic        w_err;
  logic        w_dp;
  logic        w_in_region;
  logic        w_out_region;
  logic        w_key_region;
  logic [1:0]  w_slot;
  logic [1:0]  w_wsel;
  logic        w_stall;
  logic        w_hready;
  logic        w_done;
  logic        w_wr_done;
  logic        w_rd_done;
  logic        w_capture;
  logic        w_in_take;
  logic        w_out_take;
  logic [31:0] w_status;
  logic [31:0] w_rdata;

  assign w_unused = &{1'b0, HBURST, HPROT, HADDR[31:8], HADDR[1:0]};

  // Address-phase legality: word index only, upper address bits ignored.
  assign w_aw = HADDR[7:2];
  assign w_ok = HWRITE ? ((w_aw == 6'd1) || (w_aw == 6'd2) || (w_aw[5:2] == 4'd1) ||
                          (w_aw[5:4] == 2'd1))
                       : ((w_aw == 6'd0) || (w_aw[5:4] == 2'd1) || (w_aw[5:4] == 2'd2));
  assign w_err = !w_ok || (HSIZE != 3'b010);

  assign w_dp         = (r_ph == PH_DATA);
  assign w_in_region  = (r_dp_word[5:4] == 2'd1);
  assign w_out_region = (r_dp_word[5:4] == 2'd2);
  assign w_key_region = (r_dp_word[5:2] == 4'd1);
  assign w_slot       = r_dp_word[3:2];
  assign w_wsel       = r_dp_word[1:0];

  // Any write into a still-occupied input slot waits for the core to drain it.
  assign w_stall    = w_dp && r_dp_write && w_in_region && r_in_full[w_slot];
  assign w_hready   = (r_ph != PH_ERR1) && !w_stall;
  assign w_done     = w_dp && w_hready;
  assign w_wr_done  = w_done && r_dp_write;
  assign w_rd_done  = w_done && !r_dp_write;
  assign w_capture  = HSELx && HTRANS[1] && w_hready;
  assign w_in_take  = r_in_full[r_in_rd] && in_ready;
  assign w_out_take = out_valid && !r_out_full[r_out_wr];

  assign w_status = {22'd0, r_out_full, r_in_full, r_mode, r_key_loaded};

  always_comb begin
    w_rdata = '0;
    if (w_dp && !r_dp_write) begin
      if (r_dp_word == 6'd0)
        w_rdata = w_status;
      else if (w_out_region && r_out_full[w_slot])
        w_rdata = r_out_mem[w_slot][{~w_wsel, 5'b0} +: 32];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ph         <= PH_IDLE;
      r_dp_write   <= 1'b0;
      r_dp_word    <= '0;
      r_key        <= '0;
      r_key_loaded <= 1'b0;
      r_key_valid  <= 1'b0;
      r_mode       <= 1'b0;
      r_in_full    <= '0;
      r_in_rd      <= '0;
      r_out_full   <= '0;
      r_out_wr     <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        r_in_mem[i]  <= '0;
        r_out_mem[i] <= '0;
      end
    end else begin
      r_key_valid <= 1'b0;

      if (w_hready) begin
        if (w_capture) begin
          r_ph       <= w_err ? PH_ERR1 : PH_DATA;
          r_dp_write <= HWRITE;
          r_dp_word  <= w_aw;
        end else begin
          r_ph <= PH_IDLE;
        end
      end else if (r_ph == PH_ERR1) begin
        r_ph <= PH_ERR2;
      end

      // Drain clears before any bus set; a completing write never targets a full slot.
      if (w_in_take) begin
        r_in_full[r_in_rd] <= 1'b0;
        r_in_rd            <= r_in_rd + 2'd1;
      end

      if (w_wr_done) begin
        if (r_dp_word == 6'd1) r_mode <= 1'b0;
        if (r_dp_word == 6'd2) r_mode <= 1'b1;
        if (w_key_region) begin
          r_key[{~w_wsel, 5'b0} +: 32] <= HWDATA;
          if (w_wsel == 2'd3) begin
            r_key_loaded <= 1'b1;
            r_key_valid  <= 1'b1;
          end
        end
        if (w_in_region) begin
          r_in_mem[w_slot][{~w_wsel, 5'b0} +: 32] <= HWDATA;
          if (w_wsel == 2'd3) r_in_full[w_slot] <= 1'b1;
        end
      end

      if (w_rd_done && w_out_region && (w_wsel == 2'd3))
        r_out_full[w_slot] <= 1'b0;

      if (w_out_take) begin
        r_out_mem[r_out_wr]  <= out_block;
        r_out_full[r_out_wr] <= 1'b1;
        r_out_wr             <= r_out_wr + 2'd1;
      end
    end
  end

  assign HREADY    = w_hready;
  assign HRESP     = ((r_ph == PH_ERR1) || (r_ph == PH_ERR2)) ? 2'b01 : 2'b00;
  assign HRDATA    = w_rdata;
  assign key_out   = r_key;
  assign key_valid = r_key_valid;
  assign mode      = r_mode;
  assign in_block  = r_in_mem[r_in_rd];
  assign in_valid  = r_in_full[r_in_rd];
  assign out_ready = !r_out_full[r_out_wr];

endmodule

// File: tb/tb_aes_ahb_slave_if.sv
// Scoreboard bench for aes_ahb_slave_if: a register-map model predicts bus, key and
// input-block responses; a monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_aes_ahb_slave_if;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         HSELx;
  logic [31:0]  HADDR;
  logic [31:0]  HWDATA;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [2:0]   HBURST;
  logic [3:0]   HPROT;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [127:0] key_out;
  logic         key_valid;
  logic         mode;
  logic [127:0] in_block;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_block;
  logic         out_valid;
  logic         out_ready;

  aes_ahb_slave_if #(.NUM_SLOTS(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HADDR(HADDR), .HWDATA(HWDATA),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .key_out(key_out),
    .key_valid(key_valid), .mode(mode), .in_block(in_block), .in_valid(in_valid),
    .in_ready(in_ready), .out_block(out_block), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] rdata;
  } bexp_t;

  bexp_t        bus_q[$];
  logic [127:0] in_q[$];
  logic [127:0] key_q[$];

  int checks = 0;
  int errors = 0;

  logic         m_mode, m_kl;
  logic [31:0]  m_key [4];
  logic [31:0]  m_in  [4][4];
  logic [3:0]   m_in_full;
  logic [127:0] m_out [4];
  logic [3:0]   m_out_full;
  int           m_out_wr;
  int           nxt_slot;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 1'b0; m_kl = 1'b0; m_in_full = '0; m_out_full = '0; m_out_wr = 0; nxt_slot = 0;
    for (int i = 0; i < 4; i++) m_key[i] = '0;
  endtask

  // Register-map rules applied at issue time; pushes the bus expectation.
  task automatic model_issue(input logic [7:0] a8, input logic wr, input logic [31:0] wd,
                             input logic [2:0] sz);
    bexp_t e;
    int a, k, w;
    logic ok;
    a = int'({a8[7:2], 2'b00});
    if (sz != 3'd2) ok = 1'b0;
    else if (wr) ok = (a == 4) || (a == 8) || (a >= 16 && a <= 28) || (a >= 64 && a <= 124);
    else ok = (a == 0) || (a >= 64 && a <= 188);
    e.rd = !wr; e.err = !ok; e.rdata = '0;
    if (ok && wr) begin
      if (a == 4) m_mode = 1'b0;
      else if (a == 8) m_mode = 1'b1;
      else if (a >= 16 && a <= 28) begin
        m_key[(a - 16) / 4] = wd;
        if (a == 28) begin
          m_kl = 1'b1;
          key_q.push_back({m_key[0], m_key[1], m_key[2], m_key[3]});
        end
      end else begin
        k = (a - 64) / 16; w = (a / 4) % 4;
        m_in[k][w] = wd;
        if (w == 3) begin
          in_q.push_back({m_in[k][0], m_in[k][1], m_in[k][2], m_in[k][3]});
          m_in_full[k] = 1'b1;
        end
      end
    end else if (ok) begin
      if (a == 0) e.rdata = {22'd0, m_out_full, m_in_full, m_mode, m_kl};
      else if (a >= 128) begin
        k = (a - 128) / 16; w = (a / 4) % 4;
        if (m_out_full[k]) e.rdata = m_out[k][127 - 32 * w -: 32];
        if (w == 3) m_out_full[k] = 1'b0;
      end
    end
    bus_q.push_back(e);
  endtask

  // Single non-pipelined transfer; called at posedge+1 with the bus idle.
  task automatic bus_xfer(input logic [7:0] a8, input logic wr, input logic [31:0] wd,
                          input logic [2:0] sz);
    logic [31:0] hi;
    logic got;
    hi = $urandom();
    model_issue(a8, wr, wd, sz);
    HSELx = 1'b1; HTRANS = 2'b10; HADDR = {hi[31:8], a8}; HWRITE = wr; HSIZE = sz;
    HBURST = 3'b001; HPROT = 4'b0011;
    @(posedge HCLK); #1;
    HSELx = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge HCLK);
      got = HREADY;
    end
    chk("bus_complete", got, 1'b1);
    @(posedge HCLK); #1;
  endtask

  task automatic core_push(input logic [127:0] b);
    logic got;
    m_out[m_out_wr] = b; m_out_full[m_out_wr] = 1'b1; m_out_wr = (m_out_wr + 1) % 4;
    out_block = b; out_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge HCLK);
      got = out_ready;
    end
    chk("push_accept", got, 1'b1);
    @(posedge HCLK); #1;
    out_valid = 1'b0;
  endtask

  task automatic write_block(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
    logic [7:0] base;
    base = 8'h40 + 8'(nxt_slot * 16);
    nxt_slot = (nxt_slot + 1) % 4;
    bus_xfer(base,        1'b1, w0, 3'd2);
    bus_xfer(base + 8'd4, 1'b1, w1, 3'd2);
    bus_xfer(base + 8'd8, 1'b1, w2, 3'd2);
    bus_xfer(base + 8'd12, 1'b1, w3, 3'd2);
  endtask

  task automatic drain();
    in_ready = 1'b1;
    repeat (12) @(posedge HCLK);
    #1;
    m_in_full = '0;
  endtask

  // Monitor: bus completions, input handshakes and key pulses.
  logic  pend, p_rdy;
  logic [1:0] p_resp;
  bexp_t me;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      pend = 1'b0; p_rdy = 1'b1; p_resp = 2'b00;
    end else begin
      if (pend && HREADY) begin
        chk("bus_expect_avail", bus_q.size() > 0, 1'b1);
        if (bus_q.size() > 0) begin
          me = bus_q.pop_front();
          chk("hresp", HRESP, me.err ? 2'b01 : 2'b00);
          if (me.err) chk("err_cycle1", {p_rdy, p_resp}, 3'b001);
          else if (me.rd) chk("hrdata", HRDATA, me.rdata);
        end
        pend = 1'b0;
      end
      if (HSELx && HTRANS[1] && HREADY) pend = 1'b1;
      if (in_valid && in_ready) begin
        chk("in_expect_avail", in_q.size() > 0, 1'b1);
        if (in_q.size() > 0) chk("in_block", in_block, in_q.pop_front());
      end
      if (key_valid) begin
        chk("key_expect_avail", key_q.size() > 0, 1'b1);
        if (key_q.size() > 0) chk("key_out", key_out, key_q.pop_front());
      end
      p_rdy = HREADY; p_resp = HRESP;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    logic [7:0] ra;
    HRESETn = 1'b0; HSELx = 1'b0; HADDR = '0; HWDATA = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = '0; HPROT = '0; in_ready = 1'b0; out_block = '0; out_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_hready", HREADY, 1'b1);
    chk("rst_hresp", HRESP, 2'b00);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_key_out", key_out, 128'd0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_mode", mode, 1'b0);
    chk("rst_in_valid", in_valid, 1'b0);
    chk("rst_out_ready", out_ready, 1'b1);
    @(posedge HCLK); #1;

    bus_xfer(8'h10, 1'b1, 32'h74686973, 3'd2);
    bus_xfer(8'h14, 1'b1, 32'h69737468, 3'd2);
    bus_xfer(8'h18, 1'b1, 32'h656b6579, 3'd2);
    bus_xfer(8'h1C, 1'b1, 32'h30303030, 3'd2);
    chk("key_literal", key_out, 128'h74686973_69737468_656b6579_30303030);
    bus_xfer(8'h00, 1'b0, 32'd0, 3'd2);

    bus_xfer(8'h08, 1'b1, $urandom(), 3'd2);
    chk("mode_dec", mode, 1'b1);
    bus_xfer(8'h00, 1'b0, 32'd0, 3'd2);
    bus_xfer(8'h04, 1'b1, $urandom(), 3'd2);
    chk("mode_enc", mode, 1'b0);

    in_ready = 1'b1;
    for (int b = 0; b < 4; b++) write_block($urandom(), $urandom(), $urandom(), $urandom());
    drain();
    bus_xfer(8'h00, 1'b0, 32'd0, 3'd2);

    in_ready = 1'b0;
    for (int b = 0; b < 4; b++) write_block($urandom(), $urandom(), $urandom(), $urandom());
    bus_xfer(8'h00, 1'b0, 32'd0, 3'd2);
    nxt_slot = 1;
    fork
      bus_xfer(8'h40, 1'b1, 32'hA5A5_0000, 3'd2);
      begin
        repeat (4) @(negedge HCLK);
        chk("stall_hready", HREADY, 1'b0);
        chk("stall_hresp", HRESP, 2'b00);
        @(posedge HCLK); #1 in_ready = 1'b1;
        @(posedge HCLK); #1 in_ready = 1'b0;
      end
    join
    bus_xfer(8'h44, 1'b1, 32'hA5A5_0001, 3'd2);
    bus_xfer(8'h48, 1'b1, 32'hA5A5_0002, 3'd2);
    bus_xfer(8'h4C, 1'b1, 32'hA5A5_0003, 3'd2);
    drain();

    for (int b = 0; b < 4; b++)
      core_push({$urandom(), $urandom(), $urandom(), $urandom()});
    chk("out_ready_full", out_ready, 1'b0);
    bus_xfer(8'h00, 1'b0, 32'd0, 3'd2);
    for (int i = 0; i < 16; i++) bus_xfer(8'h80 + 8'(4 * i), 1'b0, 32'd0, 3'd2);
    chk("out_ready_free", out_ready, 1'b1);
    bus_xfer(8'h84, 1'b0, 32'd0, 3'd2);

    bus_xfer(8'hC0, 1'b1, $urandom(), 3'd2);
    bus_xfer(8'h10, 1'b0, 32'd0, 3'd2);
    bus_xfer(8'h80, 1'b1, $urandom(), 3'd2);
    bus_xfer(8'h00, 1'b0, 32'd0, 3'd0);

    core_push({$urandom(), $urandom(), $urandom(), $urandom()});
    core_push({$urandom(), $urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 63) * 4);
      if (ra >= 8'h40 && ra < 8'h80) ra = 8'h00;
      bus_xfer(ra, 1'($urandom_range(0, 1)), $urandom(),
               ($urandom_range(0, 7) == 0) ? 3'd0 : 3'd2);
    end

    for (int r = 0; r < 3; r++) begin
      done = 1'b0;
      fork
        begin
          write_block($urandom(), $urandom(), $urandom(), $urandom());
          write_block($urandom(), $urandom(), $urandom(), $urandom());
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge HCLK); #1;
            if (!done) in_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      drain();
    end
    bus_xfer(8'h00, 1'b0, 32'd0, 3'd2);

    bus_xfer(8'h10, 1'b1, $urandom(), 3'd2);
    bus_xfer(8'h14, 1'b1, $urandom(), 3'd2);
    #2 HRESETn = 1'b0;
    #1 chk("reset_key_out", key_out, 128'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    model_reset();
    bus_xfer(8'h00, 1'b0, 32'd0, 3'd2);
    chk("post_reset_key_out", key_out, 128'd0);
    chk("post_reset_out_ready", out_ready, 1'b1);

    repeat (5) @(posedge HCLK);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("in_q_empty", 32'(in_q.size()), 32'd0);
    chk("key_q_empty", 32'(key_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_ahb_slave_if.md
# aes_ahb_slave_if

AHB-Lite slave front end of the AES accelerator: decodes bus transfers into control, key and data-block registers, hands 128-bit blocks to the AES core, and buffers core results for bus read-back. It sits between the system AHB-Lite fabric and the AES core inside the accelerator top level. All storage is word-addressed and big-endian within a block (lowest address = bits [127:96]).

## Interface
- NUM_SLOTS, 4, input and output block slots (fixed map requires 4)
- HCLK  in  1  bus clock; single clock domain
- HRESETn  in  1  asynchronous active-low reset
- HSELx  in  1  slave select
- HADDR  in  32  byte address; bits [7:2] decoded, upper bits ignored
- HWDATA  in  32  write data (data phase)
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write
- HSIZE  in  3  only 3'b010 (word) legal
- HBURST  in  3  accepted, not used for decode
- HPROT  in  4  ignored
- HRDATA  out  32  read data (data phase)
- HREADY  out  1  transfer complete / wait state
- HRESP  out  2  00 OKAY, 01 ERROR
- key_out  out  128  assembled key
- key_valid  out  1  one-cycle pulse when key complete
- mode  out  1  0 encrypt, 1 decrypt
- in_block  out  128  head input block to core
- in_valid  out  1  head input slot full
- in_ready  in  1  core accepts in_block when in_valid && in_ready
- out_block  in  128  core result
- out_valid  in  1  core result present
- out_ready  out  1  free output slot exists

## Operation
- Address phase captured when HSELx && HTRANS[1] && HREADY; BUSY/IDLE produce no action, OKAY response.
- Map: 0x00 status RO; 0x04 write sets mode=0; 0x08 write sets mode=1 (data ignored); 0x10–0x1C key words 0–3; 0x40–0x7C input slot k=(a-0x40)>>4, word w=(a>>2)&3; 0x80–0xBC output slot k, word w, RO.
- Status: [0] key_loaded, [1] mode, [5:2] input slot full flags, [9:6] output slot full flags, others 0.
- Key: data-phase write stores word; write to 0x1C sets key_loaded and pulses key_valid the cycle after the data phase completes.
- Input slots: write of word 3 sets slot full. Core drains in order via rd pointer (0→3 wrap); handshake clears flag, pointer advances.
- Output slots: core result written to slot at wr pointer (0→3 wrap) when out_valid && out_ready; out_ready = flag[wr_ptr]==0. Bus read of word 3 clears that slot's flag. Read of empty slot returns 0, OKAY.
- ERROR: unmapped address, write to 0x00 or 0x80–0xBC, read of 0x04/0x08/key region, HSIZE≠word. No state change.

## Timing
- Reset: HRDATA 0, HREADY 1, HRESP 00, key_out 0, key_valid 0, key_loaded 0, mode 0, all slot flags 0, pointers 0, in_valid 0, out_ready 1.
- Zero-wait OKAY: HREADY 1 in data phase; HRDATA valid in data phase from registered address (combinational from stored state).
- Write to any word of a full input slot: HREADY held 0 (HRESP OKAY) until that slot drains; write completes in the cycle HREADY returns 1.
- ERROR: two cycles — cycle 1 HREADY 0/HRESP 01, cycle 2 HREADY 1/HRESP 01; then OKAY.
- Core handshake and same-cycle bus write to the drained slot: drain wins; the stalled write completes next cycle.
- Output word-3 read and core write to same slot same cycle: impossible (core only writes empty slot); read of word 3 while core writes another slot — both take effect.
- Reset asserted mid-burst: all state cleared immediately; partial key or block discarded.
- in_block latency: in_valid rises the cycle after word-3 data phase.

## Test plan
- Key burst 0x10..0x1C with "thisisthekey0000" -> key_out = 0x74686973_69737468_656b6579_30303030, key_valid high exactly one cycle, status[0]=1.
- Write 0x08 then read 0x00 -> mode=1, status=0x2 | key bit; write 0x04 -> mode=0.
- 16-word burst 0x40..0x7C, in_ready=1 -> four in_valid handshakes, blocks in slot order 0..3, flags clear.
- Same burst with in_ready=0, then rewrite 0x40 -> HREADY low until in_ready pulses, then write completes.
- Core pushes 4 results, out_ready drops after 4th; burst read 0x80..0xBC returns words in order, flags clear, out_ready=1.
- Write 0xC0 and read 0x10 -> two-cycle ERROR each; assert HRESETn mid-key-burst -> key_loaded 0, key_out 0.
